// File: rtl/motor_drive_ctrl.sv
// -----------------------------------------------------------------------------
// motor_drive_ctrl
//
// Soft-start / soft-stop motor drive controller. A start pulse from the
// upstream grant FSM arms the block; once the grant level is seen the duty
// ramps up one LSB every STEP_CYCLES clocks until DUTY_MAX, holds there,
// and ramps back down to zero on an operator stop. Losing the grant while
// the motor is energised, or never receiving it while armed, latches a
// fault that only reset clears.
//
// Ports
//   clk         in   1        single clock, rising edge
//   resetn      in   1        asynchronous active-low reset
//   f           in   1        one-cycle start pulse (honoured only in IDLE)
//   g           in   1        grant level, high = motor permitted
//   stop        in   1        operator stop request, level
//   pwm_out     out  1        registered PWM drive, (pwm_cnt < duty)
//   duty        out  PWM_BITS current duty value
//   running     out  1        high in RUN
//   busy        out  1        high in ARMED, RAMP, RUN, RDOWN
//   fault       out  1        high in FAULT
//   fault_code  out  2        00 none, 01 grant timeout, 10 grant lost
// -----------------------------------------------------------------------------
module motor_drive_ctrl #(
    parameter int PWM_BITS    = 8,
    parameter int DUTY_MAX    = 255,
    parameter int STEP_CYCLES = 16,
    parameter int G_TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                f,
    input  logic                g,
    input  logic                stop,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                running,
    output logic                busy,
    output logic                fault,
    output logic [1:0]          fault_code
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int TMR_W  = (G_TIMEOUT > 1) ? $clog2(G_TIMEOUT) : 1;

    localparam logic [PWM_BITS-1:0] DUTY_FULL = PWM_BITS'(DUTY_MAX);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [TMR_W-1:0]    TMR_LAST  = TMR_W'(G_TIMEOUT - 1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_LOST    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RAMP,
        S_RUN,
        S_RDOWN,
        S_FAULT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PWM_BITS-1:0] duty_nxt;
    logic [STEP_W-1:0]   step_cnt;
    logic [STEP_W-1:0]   step_nxt;
    logic [TMR_W-1:0]    timer;
    logic [TMR_W-1:0]    timer_nxt;
    logic [1:0]          code_q;
    logic [1:0]          code_nxt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                step_wrap;
    logic [PWM_BITS-1:0] duty_up_v;
    logic [PWM_BITS-1:0] duty_dn_v;

    // Saturating one-LSB increment; duty can never pass the full-run value.
    function automatic logic [PWM_BITS-1:0] duty_up(input logic [PWM_BITS-1:0] d);
        return (d >= DUTY_FULL) ? DUTY_FULL : d + PWM_BITS'(1);
    endfunction

    // Floor-at-zero one-LSB decrement.
    function automatic logic [PWM_BITS-1:0] duty_dn(input logic [PWM_BITS-1:0] d);
        return (d == '0) ? '0 : d - PWM_BITS'(1);
    endfunction

    // ---- control state register -------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            duty     <= '0;
            step_cnt <= '0;
            timer    <= '0;
            code_q   <= CODE_NONE;
        end else begin
            state    <= state_nxt;
            duty     <= duty_nxt;
            step_cnt <= step_nxt;
            timer    <= timer_nxt;
            code_q   <= code_nxt;
        end
    end

    // ---- next-state / datapath decode -------------------------------------
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        step_nxt  = step_cnt;
        timer_nxt = timer;
        code_nxt  = code_q;
        step_wrap = (step_cnt == STEP_LAST);
        duty_up_v = duty_up(duty);
        duty_dn_v = duty_dn(duty);

        case (state)
            S_IDLE: begin
                if (f) begin
                    state_nxt = S_ARMED;
                    timer_nxt = '0;
                end
            end

            S_ARMED: begin
                // Grant wins over stop and over the timeout, so a grant that
                // arrives on the last permitted cycle is still accepted.
                if (g) begin
                    state_nxt = S_RAMP;
                    step_nxt  = '0;
                end else if (stop) begin
                    state_nxt = S_IDLE;
                end else if (timer == TMR_LAST) begin
                    state_nxt = S_FAULT;
                    code_nxt  = CODE_TIMEOUT;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end

            S_RAMP: begin
                if (!g) begin
                    state_nxt = S_FAULT;
                    code_nxt  = CODE_LOST;
                    duty_nxt  = '0;
                end else if (stop) begin
                    state_nxt = S_RDOWN;
                    step_nxt  = '0;
                end else if (step_wrap) begin
                    step_nxt = '0;
                    duty_nxt = duty_up_v;
                    if (duty_up_v == DUTY_FULL) begin
                        state_nxt = S_RUN;
                    end
                end else begin
                    step_nxt = step_cnt + STEP_W'(1);
                end
            end

            S_RUN: begin
                duty_nxt = DUTY_FULL;
                if (!g) begin
                    state_nxt = S_FAULT;
                    code_nxt  = CODE_LOST;
                    duty_nxt  = '0;
                end else if (stop) begin
                    state_nxt = S_RDOWN;
                    step_nxt  = '0;
                end
            end

            S_RDOWN: begin
                // Stop is no longer looked at: a ramp-down always finishes.
                if (!g) begin
                    state_nxt = S_FAULT;
                    code_nxt  = CODE_LOST;
                    duty_nxt  = '0;
                end else if (duty == '0) begin
                    // Stopped in RAMP before the first step: nothing to ramp.
                    state_nxt = S_IDLE;
                end else if (step_wrap) begin
                    step_nxt = '0;
                    duty_nxt = duty_dn_v;
                    if (duty_dn_v == '0) begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    step_nxt = step_cnt + STEP_W'(1);
                end
            end

            S_FAULT: begin
                duty_nxt = '0;
            end

            default: begin
                state_nxt = S_IDLE;
                duty_nxt  = '0;
            end
        endcase
    end

    // ---- PWM generation: free-running counter, registered compare ---------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            pwm_out <= (pwm_cnt < duty);
        end
    end

    // Status is decoded from registered state only. code_q is written only
    // on entry to FAULT, but is gated anyway so it reads 00 elsewhere.
    assign running    = (state == S_RUN);
    assign busy       = (state == S_ARMED) || (state == S_RAMP) ||
                        (state == S_RUN)   || (state == S_RDOWN);
    assign fault      = (state == S_FAULT);
    assign fault_code = (state == S_FAULT) ? code_q : CODE_NONE;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// -----------------------------------------------------------------------------
// tb_motor_drive_ctrl
//
// Directed scenarios followed by a randomized run, all checked every cycle
// against a phase-level reference model: duty is computed from the number
// of cycles spent in the current ramp phase rather than from step counters.
// -----------------------------------------------------------------------------
module tb_motor_drive_ctrl;

    localparam int PB      = 3;
    localparam int DMAX    = 4;
    localparam int STEPC   = 2;
    localparam int GTO     = 8;
    localparam int CNT_MOD = 1 << PB;

    // Model phases
    localparam int MI = 0;  // idle
    localparam int MA = 1;  // armed, waiting for grant
    localparam int MU = 2;  // ramping up
    localparam int MF = 3;  // full duty
    localparam int MD = 4;  // ramping down
    localparam int MX = 5;  // fault

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          f      = 1'b0;
    logic          g      = 1'b0;
    logic          stop   = 1'b0;
    logic          pwm_out;
    logic [PB-1:0] duty;
    logic          running;
    logic          busy;
    logic          fault;
    logic [1:0]    fault_code;

    int total = 0;
    int bad   = 0;

    motor_drive_ctrl #(
        .PWM_BITS    (PB),
        .DUTY_MAX    (DMAX),
        .STEP_CYCLES (STEPC),
        .G_TIMEOUT   (GTO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .f          (f),
        .g          (g),
        .stop       (stop),
        .pwm_out    (pwm_out),
        .duty       (duty),
        .running    (running),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_mode;   // current phase
    int m_t;      // cycles elapsed in current phase
    int m_base;   // duty at start of a ramp-down
    int m_code;   // fault reason
    int m_cnt;    // PWM counter value
    int m_pwm;    // expected registered PWM output

    function automatic int m_duty();
        int d;
        case (m_mode)
            MU: begin
                d = m_t / STEPC;
                if (d > DMAX) d = DMAX;
            end
            MF: d = DMAX;
            MD: begin
                d = m_base - m_t / STEPC;
                if (d < 0) d = 0;
            end
            default: d = 0;
        endcase
        return d;
    endfunction

    task automatic model_reset();
        m_mode = MI; m_t = 0; m_base = 0; m_code = 0; m_cnt = 0; m_pwm = 0;
    endtask

    task automatic model_edge(input logic fi, input logic gi, input logic si);
        int d;
        d = m_duty();
        m_pwm = (m_cnt < d) ? 1 : 0;
        m_cnt = (m_cnt + 1) % CNT_MOD;
        case (m_mode)
            MI: if (fi) begin m_mode = MA; m_t = 0; end
            MA: begin
                if (gi) begin m_mode = MU; m_t = 0; end
                else if (si) m_mode = MI;
                else if (m_t == GTO - 1) begin m_mode = MX; m_code = 1; end
                else m_t++;
            end
            MU: begin
                if (!gi) begin m_mode = MX; m_code = 2; end
                else if (si) begin m_mode = MD; m_base = d; m_t = 0; end
                else begin
                    m_t++;
                    if (m_duty() == DMAX) m_mode = MF;
                end
            end
            MF: begin
                if (!gi) begin m_mode = MX; m_code = 2; end
                else if (si) begin m_mode = MD; m_base = DMAX; m_t = 0; end
            end
            MD: begin
                if (!gi) begin m_mode = MX; m_code = 2; end
                else if (d == 0) m_mode = MI;
                else begin
                    m_t++;
                    if (m_duty() == 0) m_mode = MI;
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".duty"},       32'(duty),       m_duty());
        check({where, ".running"},    32'(running),    (m_mode == MF) ? 1 : 0);
        check({where, ".busy"},       32'(busy),       (m_mode >= MA && m_mode <= MD) ? 1 : 0);
        check({where, ".fault"},      32'(fault),      (m_mode == MX) ? 1 : 0);
        check({where, ".fault_code"}, 32'(fault_code), (m_mode == MX) ? m_code : 0);
        check({where, ".pwm_out"},    32'(pwm_out),    m_pwm);
    endtask

    // Drive inputs just after an edge, let one rising edge pass, check.
    task automatic tick(input string where, input logic fi, input logic gi, input logic si);
        f = fi; g = gi; stop = si;
        model_edge(fi, gi, si);
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset(input string where);
        #3;
        resetn = 1'b0;
        f = 1'b0; g = 1'b0; stop = 1'b0;
        model_reset();
        #1;
        check_all({where, ".async"});
        @(posedge clk);
        #1;
        check_all({where, ".held"});
        resetn = 1'b1;
    endtask

    task automatic ramp_to_run(input string where);
        tick(where, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && m_mode != MF; i++) tick(where, 1'b0, 1'b1, 1'b0);
        check({where, ".reached_run"}, 32'(running), 1);
    endtask

    initial begin
        int   hi;
        logic gl, fi, si;

        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        resetn = 1'b1;
        tick("post_reset", 1'b0, 1'b0, 1'b0);

        // Ramp 0..4 at 2-cycle steps, then hold; PWM high 4 of every 8.
        ramp_to_run("ramp_up");
        hi = 0;
        for (int i = 0; i < CNT_MOD; i++) begin
            tick("run_pwm", 1'b0, 1'b1, 1'b0);
            hi += int'(pwm_out);
        end
        check("run_pwm_high_count", 32'(hi), DMAX);

        // Stop in RUN: 4,3,2,1,0 then IDLE; stop released mid-way is ignored.
        tick("stop_run", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 30 && m_mode != MI; i++) tick("rdown", 1'b0, 1'b1, (i % 3) == 0);
        check("rdown_done.busy", 32'(busy), 0);
        check("rdown_done.fault", 32'(fault), 0);

        // Stop in RAMP at duty 2: 2,1,0 then IDLE.
        tick("ramp2_f", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_duty() != 2; i++) tick("ramp2", 1'b0, 1'b1, 1'b0);
        check("ramp2_at_two", 32'(duty), 2);
        tick("ramp2_stop", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20 && m_mode != MI; i++) tick("ramp2_down", 1'b0, 1'b1, 1'b0);
        check("ramp2_idle.busy", 32'(busy), 0);

        // RUN with stop and grant loss together: grant loss wins.
        ramp_to_run("lost");
        tick("lost_edge", 1'b0, 1'b0, 1'b1);
        check("lost.fault_code", 32'(fault_code), 2);
        check("lost.duty", 32'(duty), 0);
        tick("lost_pwm", 1'b0, 1'b0, 1'b0);
        check("lost.pwm_out", 32'(pwm_out), 0);
        tick("lost_ign_f", 1'b1, 1'b1, 1'b0);
        tick("lost_ign_s", 1'b0, 1'b1, 1'b1);
        async_reset("rst_in_fault");

        // Grant on the last permitted ARMED cycle is accepted.
        tick("late_g_f", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < GTO - 1; i++) tick("late_g_wait", 1'b0, 1'b0, 1'b0);
        tick("late_g", 1'b0, 1'b1, 1'b0);
        check("late_g.fault", 32'(fault), 0);
        check("late_g.busy", 32'(busy), 1);
        async_reset("rst_late_g");

        // Grant never comes: timeout fault after the 8th ARMED cycle.
        tick("tmo_f", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < GTO; i++) tick("tmo_wait", 1'b0, 1'b0, 1'b0);
        check("tmo.fault", 32'(fault), 1);
        check("tmo.fault_code", 32'(fault_code), 1);
        tick("tmo_ign_f", 1'b1, 1'b0, 1'b0);
        tick("tmo_ign_g", 1'b0, 1'b1, 1'b0);
        async_reset("rst_tmo");

        // Reset mid-ramp.
        tick("midramp_f", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_duty() != 2; i++) tick("midramp", 1'b0, 1'b1, 1'b0);
        tick("midramp_hold", 1'b0, 1'b1, 1'b0);
        async_reset("rst_midramp");
        check("rst_midramp.pwm_out", 32'(pwm_out), 0);

        // Randomized traffic with occasional resets.
        gl = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) gl = ~gl;
            fi = ($urandom_range(0, 7) == 0);
            si = ($urandom_range(0, 11) == 0);
            tick("rand", fi, gl, si);
            if ((m_mode == MX && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
                async_reset("rand_rst");
                gl = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_drive_ctrl.md
MOTOR_DRIVE_CTRL -- requirements
Module: motor_drive_ctrl

Interface
REQ-001 The block SHALL have parameter PWM_BITS, default 8, giving the width of the duty value and the PWM counter.
REQ-002 The block SHALL have parameter DUTY_MAX, default 255, giving the full-run duty; legal range 1..2^PWM_BITS-1.
REQ-003 The block SHALL have parameter STEP_CYCLES, default 16, giving the clock cycles per one-LSB duty change during ramps; minimum 1.
REQ-004 The block SHALL have parameter G_TIMEOUT, default 64, giving the maximum cycles spent in ARMED waiting for g; minimum 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port f, input, 1 bit: one-cycle start pulse from the upstream grant FSM.
REQ-008 The block SHALL have port g, input, 1 bit: grant level from the upstream grant FSM; high means motor permitted.
REQ-009 The block SHALL have port stop, input, 1 bit: operator stop request, level, sampled each cycle.
REQ-010 The block SHALL have port pwm_out, output, 1 bit: registered motor PWM drive.
REQ-011 The block SHALL have port duty, output, PWM_BITS bits: current duty value.
REQ-012 The block SHALL have port running, output, 1 bit: high only in state RUN.
REQ-013 The block SHALL have port busy, output, 1 bit: high in ARMED, RAMP, RUN and RDOWN.
REQ-014 The block SHALL have port fault, output, 1 bit: high only in state FAULT.
REQ-015 The block SHALL have port fault_code, output, 2 bits: 00 none, 01 grant timeout, 10 grant lost; held while in FAULT.

Function
REQ-016 The block SHALL implement states IDLE, ARMED, RAMP, RUN, RDOWN and FAULT.
REQ-017 In IDLE, f=1 SHALL move the FSM to ARMED and clear the timeout timer; f in any other state SHALL be ignored and SHALL NOT restart the timer.
REQ-018 In ARMED with g=1, the FSM SHALL move to RAMP with the step counter cleared; stop=1 without g SHALL return it to IDLE.
REQ-019 In ARMED with g=0, the timer SHALL increment each cycle; when it reaches G_TIMEOUT-1 with g=0, the FSM SHALL move to FAULT with code 01, so g high on the G_TIMEOUT-th ARMED cycle is still accepted.
REQ-020 In RAMP, the step counter SHALL count 0..STEP_CYCLES-1 and wrap; at each wrap duty SHALL increment by 1.
REQ-021 When duty reaches DUTY_MAX in RAMP, the FSM SHALL move to RUN on the same edge; duty SHALL never exceed DUTY_MAX.
REQ-022 In RUN, duty SHALL hold at DUTY_MAX; stop=1 SHALL move the FSM to RDOWN with the step counter cleared.
REQ-023 In RAMP, stop=1 SHALL move the FSM to RDOWN from the current duty without incrementing it.
REQ-024 In RDOWN, duty SHALL decrement by 1 at each step-counter wrap; when duty reaches 0 the FSM SHALL move to IDLE; stop deassertion SHALL NOT resume the ramp.
REQ-025 In RAMP, RUN or RDOWN, g=0 SHALL move the FSM to FAULT with code 10 and force duty to 0 on the same edge.
REQ-026 g=0 SHALL take priority over a simultaneous stop=1, and over a simultaneous ramp step.
REQ-027 FAULT SHALL be absorbing: f, g and stop SHALL be ignored, duty SHALL be 0, and only reset SHALL exit it.
REQ-028 The PWM counter SHALL be PWM_BITS wide, free-running from reset, and wrap from 2^PWM_BITS-1 to 0.
REQ-029 pwm_out SHALL be registered as (pwm_cnt < duty), giving one cycle of latency; duty=0 SHALL give a constant 0.
REQ-030 running, busy, fault and fault_code SHALL be decoded from the state register only, with no combinational path from the inputs.

Reset
REQ-031 When resetn=0, the block SHALL go immediately to state IDLE, independent of clk.
REQ-032 When resetn=0, the block SHALL clear duty, pwm_cnt, the step counter and the timer to 0.
REQ-033 When resetn=0, the block SHALL drive pwm_out=0, running=0, busy=0, fault=0 and fault_code=00.
REQ-034 When resetn=0 mid-ramp or in FAULT, the block SHALL drop pwm_out to 0 without waiting for a clock edge.
REQ-035 After resetn rises, the first rising edge SHALL be a normal IDLE cycle.

Verification
REQ-036 The bench SHALL cover, with PWM_BITS=3, DUTY_MAX=4, STEP_CYCLES=2: f pulse, then g=1 next cycle -> duty 1,2,3,4 at 2-cycle intervals, then running=1; pwm_out high 4 of every 8 cycles.
REQ-037 The bench SHALL cover, with G_TIMEOUT=8: f pulse, g held 0 -> fault=1, fault_code=01 after the 8th ARMED cycle; a further f is ignored.
REQ-038 The bench SHALL cover: in RUN, stop=1 and g=0 in the same cycle -> FAULT with code 10, duty=0 next cycle, pwm_out=0 one cycle later.
REQ-039 The bench SHALL cover: stop=1 in RUN -> duty 4,3,2,1,0 at 2-cycle steps, then IDLE with busy=0 and no fault.
REQ-040 The bench SHALL cover: stop=1 in RAMP at duty=2 -> duty falls 2,1,0, then IDLE.
REQ-041 The bench SHALL cover: resetn=0 asynchronously mid-RAMP and in FAULT -> all outputs 0 before the next clk edge.
